mult_div_unit: RTL and testbench

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

---
 rtl/mult_div_unit.sv | 163 ++++++++++++++++
 tb/tb_mult_div_unit.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit with HI/LO result registers.
// One radix-2 step per cycle on operand magnitudes, followed by a single
// sign-correction cycle; MTHI/MTLO write HI/LO directly when idle.
module mult_div_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

   state_t           state, stateNext;
   logic [CW-1:0]    count;
   logic             canAccept, acceptArith;
   logic             aNeg, bNeg;
   logic [WIDTH-1:0] aMag, bMag;

   // latched operation context and iteration registers (HI:LO working pair)
   logic             isDiv, isSigned, negA, negB;
   logic [WIDTH-1:0] srcA, opB, accHi, accLo;

   logic [WIDTH:0]   mulSum, divTrial;
   logic [WIDTH-1:0] stepHi, stepLo;
   logic [WIDTH-1:0] resHi, resLo;
   logic [2*WIDTH-1:0] prodRes;

   // two's-complement negate when requested
   function automatic logic [WIDTH-1:0] condNeg(input logic [WIDTH-1:0] v, input logic neg);
      logic signed [WIDTH-1:0] s;
      s = $signed(v);
      return neg ? $unsigned(-s) : v;
   endfunction

   // double-width negate for the full product
   function automatic logic [2*WIDTH-1:0] condNeg2(input logic [2*WIDTH-1:0] v, input logic neg);
      logic signed [2*WIDTH-1:0] s;
      s = $signed(v);
      return neg ? $unsigned(-s) : v;
   endfunction

   assign canAccept   = (state == IDLE) || (state == DONE);
   assign acceptArith = canAccept && start && (op[2] == 1'b0);
   assign aNeg        = (op[0] == 1'b0) && ($signed(a) < 0);
   assign bNeg        = (op[0] == 1'b0) && ($signed(b) < 0);
   assign aMag        = condNeg(a, aNeg);
   assign bMag        = condNeg(b, bNeg);

   // state register and iteration counter
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         count <= '0;
      end else begin
         state <= stateNext;
         if (acceptArith)
            count <= CW'(WIDTH);
         else if (state == CALC)
            count <= count - CW'(1);
      end
   end

   // next-state decode and status outputs
   always_comb begin
      stateNext = state;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE: if (acceptArith) stateNext = CALC;
         CALC: begin
            busy = 1'b1;
            if (count == CW'(1)) stateNext = FIX;
         end
         FIX: begin
            busy      = 1'b1;
            stateNext = DONE;
         end
         DONE: begin
            done      = 1'b1;
            stateNext = acceptArith ? CALC : IDLE;
         end
         default: stateNext = IDLE;
      endcase
   end

   // one shift-add or restoring-division step on the working pair
   always_comb begin
      mulSum   = {1'b0, accHi} + (accLo[0] ? {1'b0, opB} : '0);
      divTrial = {accHi, accLo[WIDTH-1]} - {1'b0, opB};
      if (isDiv) begin
         if (divTrial[WIDTH] == 1'b0) begin
            stepHi = divTrial[WIDTH-1:0];
            stepLo = {accLo[WIDTH-2:0], 1'b1};
         end else begin
            stepHi = {accHi[WIDTH-2:0], accLo[WIDTH-1]};
            stepLo = {accLo[WIDTH-2:0], 1'b0};
         end
      end else begin
         stepHi = mulSum[WIDTH:1];
         stepLo = {mulSum[0], accLo[WIDTH-1:1]};
      end
   end

   // sign correction and divide-by-zero handling of the magnitude result
   always_comb begin
      prodRes = condNeg2({accHi, accLo}, isSigned && (negA ^ negB));
      if (isDiv) begin
         if (opB == '0) begin
            resLo = '1;
            resHi = srcA;
         end else begin
            resLo = condNeg(accLo, isSigned && (negA ^ negB));
            resHi = condNeg(accHi, isSigned && negA);
         end
      end else begin
         resHi = prodRes[2*WIDTH-1:WIDTH];
         resLo = prodRes[WIDTH-1:0];
      end
   end

   // architectural HI/LO: cleared by reset, written by FIX or MTHI/MTLO
   always_ff @(posedge clk) begin
      if (rst) begin
         hi <= '0;
         lo <= '0;
      end else if (state == FIX) begin
         hi <= resHi;
         lo <= resLo;
      end else if (canAccept && start && (op == 3'b100)) begin
         hi <= a;
      end else if (canAccept && start && (op == 3'b101)) begin
         lo <= a;
      end
   end

   // operand capture on accept, then iterate while calculating
   always_ff @(posedge clk) begin
      if (acceptArith) begin
         isDiv    <= op[1];
         isSigned <= ~op[0];
         negA     <= aNeg;
         negB     <= bNeg;
         srcA     <= a;
         opB      <= op[1] ? bMag : aMag;
         accHi    <= '0;
         accLo    <= op[1] ? aMag : bMag;
      end else if (state == CALC) begin
         accHi <= stepHi;
         accLo <= stepLo;
      end
   end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit (WIDTH=32): directed corner cases
// plus randomized operations checked against a plain-arithmetic model.
module tb_mult_div_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [2:0]  op;
   logic [31:0] a, b;
   logic        busy, done;
   logic [31:0] hi, lo;

   int vectors     = 0;
   int miscompares = 0;

   mult_div_unit #(.WIDTH(32)) dut (
      .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
      .busy(busy), .done(done), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      assert (got === exp)
      else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // expected {hi,lo} straight from the arithmetic definitions
   function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
      longint p;
      int     q, r;
      case (o)
         3'd0: begin
            p = longint'($signed(x)) * longint'($signed(y));
            return p;
         end
         3'd1: return {32'b0, x} * {32'b0, y};
         3'd2: begin
            if (y == 0) return {x, 32'hFFFF_FFFF};
            if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
            q = $signed(x) / $signed(y);
            r = $signed(x) % $signed(y);
            return {r, q};
         end
         default: begin
            if (y == 0) return {x, 32'hFFFF_FFFF};
            return {x % y, x / y};
         end
      endcase
   endfunction

   // issue one arithmetic op, optionally inject a stray start mid-CALC
   task automatic runOp(input string tag, input logic [2:0] o, input logic [31:0] x,
                        input logic [31:0] y, input int injAt, input logic [2:0] injOp,
                        input bit trail);
      logic [63:0] exp;
      logic [31:0] hiBefore, loBefore;
      int          cycles;
      bit          holdBad;
      exp   = model(o, x, y);
      start = 1'b1; op = o; a = x; b = y;
      tick();
      start    = 1'b0;
      hiBefore = hi;
      loBefore = lo;
      cycles   = 0;
      holdBad  = 1'b0;
      while (busy && cycles < 100) begin
         cycles++;
         if (hi !== hiBefore || lo !== loBefore) holdBad = 1'b1;
         a = $urandom; b = $urandom; op = 3'($urandom_range(0, 7));
         start = (cycles == injAt);
         if (cycles == injAt) op = injOp;
         tick();
         start = 1'b0;
      end
      check({tag, ".busyCycles"}, 64'(cycles), 64'd33);
      check({tag, ".hold"}, 64'(holdBad), 64'd0);
      check({tag, ".done"}, 64'(done), 64'd1);
      check({tag, ".hilo"}, {hi, lo}, exp);
      if (trail) begin
         tick();
         check({tag, ".doneOff"}, {62'd0, done, busy}, 64'd0);
      end
   endtask

   initial begin
      bit sawDone;
      rst = 1'b1; start = 1'b0; op = 3'd0; a = '0; b = '0;
      tick();
      tick();
      check("reset.outputs", {30'd0, busy, done, hi}, 64'd0);
      check("reset.lo", 64'(lo), 64'd0);
      rst = 1'b0;
      tick();

      // MTHI/MTLO in idle: immediate write, no busy/done
      start = 1'b1; op = 3'b100; a = 32'h1234_5678;
      tick();
      start = 1'b0;
      check("mthi.hi", 64'(hi), 64'h1234_5678);
      check("mthi.flags", {62'd0, busy, done}, 64'd0);
      start = 1'b1; op = 3'b101; a = 32'hCAFE_F00D;
      tick();
      start = 1'b0;
      check("mtlo.lo", 64'(lo), 64'hCAFE_F00D);

      // reserved opcode does nothing
      start = 1'b1; op = 3'b110; a = 32'hDEAD_BEEF; b = 32'h1;
      tick();
      start = 1'b0;
      tick();
      check("op110.state", {30'd0, busy, done, hi}, {32'd0, 32'h1234_5678});
      check("op110.lo", 64'(lo), 64'hCAFE_F00D);

      // directed corner cases
      runOp("mult.neg2x3", 3'd0, 32'hFFFF_FFFE, 32'd3, 0, 3'd0, 1'b1);
      runOp("multu.max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 3'd0, 1'b1);
      runOp("div.m7by2", 3'd2, 32'hFFFF_FFF9, 32'd2, 0, 3'd0, 1'b1);
      runOp("divu.by0", 3'd3, 32'd7, 32'd0, 0, 3'd0, 1'b1);
      runOp("div.by0neg", 3'd2, 32'hFFFF_FF00, 32'd0, 0, 3'd0, 1'b1);
      runOp("div.ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 10, 3'd2, 1'b1);
      runOp("mult.mtloBusy", 3'd0, 32'h0001_0000, 32'h0001_0000, 5, 3'd5, 1'b1);
      runOp("mult.mthiBusy", 3'd1, 32'h8000_0001, 32'd2, 20, 3'd4, 1'b1);
      // back-to-back: second start issued during the DONE cycle
      runOp("chain.first", 3'd0, 32'h7FFF_FFFF, 32'h8000_0000, 0, 3'd0, 1'b0);
      runOp("chain.second", 3'd2, 32'd100, 32'hFFFF_FFF9, 0, 3'd0, 1'b1);

      // reset aborts a division in progress
      start = 1'b1; op = 3'd2; a = 32'd1000; b = 32'd7;
      tick();
      start = 1'b0;
      repeat (9) tick();
      rst = 1'b1;
      tick();
      check("abort.flags", {62'd0, busy, done}, 64'd0);
      check("abort.hilo", {hi, lo}, 64'd0);
      rst     = 1'b0;
      sawDone = 1'b0;
      repeat (40) begin
         tick();
         if (done) sawDone = 1'b1;
      end
      check("abort.noDone", 64'(sawDone), 64'd0);
      runOp("afterAbort.mult", 3'd0, 32'hFFFF_FFF0, 32'hFFFF_FFF0, 0, 3'd0, 1'b1);

      // randomized operations
      for (int i = 0; i < 24; i++) begin
         logic [2:0]  ro;
         logic [31:0] ra, rb;
         ro = 3'($urandom_range(0, 3));
         ra = $urandom;
         rb = $urandom;
         if (i % 6 == 0) rb = 32'd0;
         else if (i % 3 == 1) rb = $urandom_range(1, 100);
         if (i % 4 == 2) rb = -rb;
         runOp($sformatf("rand%0d.op%0d", i, ro), ro, ra, rb, (i % 5 == 0) ? 7 : 0, 3'($urandom_range(0, 5)), 1'b1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
